// File: rtl/bcd_digit_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_converter_if
// Bundles the request and result signals of bcd_digit_converter.
//   i_clear    : synchronous clear, zeroes results and aborts a conversion
//   i_start    : conversion request, honoured only while the converter is idle
//   i_value    : unsigned binary operand, DATA_WIDTH bits
//   o_busy     : converter is shifting or presenting its result
//   o_done     : one-cycle pulse, results just updated
//   o_bcd      : packed BCD digits, digit 0 (ones) in [3:0]
//   o_digit_en : leading-zero blank mask, bit k high if digit k is significant
//   o_overflow : last operand did not fit in DIGITS decimal digits
// master modport drives requests (bench / client), slave modport is the
// converter itself.
// ---------------------------------------------------------------------------
interface bcd_digit_converter_if #(
  parameter int DATA_WIDTH = 14,
  parameter int DIGITS     = 4
);
  logic                    i_clear;
  logic                    i_start;
  logic [DATA_WIDTH-1:0]   i_value;
  logic                    o_busy;
  logic                    o_done;
  logic [4*DIGITS-1:0]     o_bcd;
  logic [DIGITS-1:0]       o_digit_en;
  logic                    o_overflow;

  modport master (
    output i_clear,
    output i_start,
    output i_value,
    input  o_busy,
    input  o_done,
    input  o_bcd,
    input  o_digit_en,
    input  o_overflow
  );

  modport slave (
    input  i_clear,
    input  i_start,
    input  i_value,
    output o_busy,
    output o_done,
    output o_bcd,
    output o_digit_en,
    output o_overflow
  );
endinterface

// File: rtl/bcd_digit_converter.sv
// ---------------------------------------------------------------------------
// bcd_digit_converter
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Ports:
//   i_clk     : clock, all state changes on its rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : bcd_digit_converter_if.slave (request + result signals)
// A request accepted in IDLE spends exactly DATA_WIDTH cycles in SHIFT, then
// one cycle in DONE with o_done high. Results are held until the next DONE,
// a clear or a reset. Only the low DIGITS decimal digits are kept; a one
// shifted out of the top nibble marks the result as overflowed.
// ---------------------------------------------------------------------------
module bcd_digit_converter #(
  parameter int DATA_WIDTH = 14,
  parameter int DIGITS     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  bcd_digit_converter_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]         work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // One double-dabble step on the working registers.
  logic [BW-1:0]         work_adj;
  logic [BW-1:0]         work_shift;
  logic [DATA_WIDTH-1:0] bin_shift;
  logic                  carry_out;
  logic                  final_ovf;
  logic [DIGITS-1:0]     en_final;
  logic                  last_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      // Nibbles >= 5 would exceed 9 after doubling; pre-add 3 so the shift
      // carries into the next digit instead.
      assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                   (work_q[4*gi +: 4] + 4'd3) :
                                   work_q[4*gi +: 4];
    end
  endgenerate

  assign carry_out  = work_adj[BW-1];
  assign work_shift = {work_adj[BW-2:0], bin_q[DATA_WIDTH-1]};
  assign bin_shift  = {bin_q[DATA_WIDTH-2:0], 1'b0};
  assign final_ovf  = carry_q | carry_out;
  assign last_shift = (cnt_q == CW'(DATA_WIDTH - 1));

  // Blanking mask of the result being loaded: a digit is significant when it
  // or any more-significant digit is nonzero; an overflowed result has hidden
  // nonzero digits above, so every kept digit is significant.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_en
      if (gi == 0) begin : g_ones
        assign en_final[gi] = 1'b1;
      end else begin : g_upper
        assign en_final[gi] = final_ovf | (|work_shift[BW-1:4*gi]);
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    bcd_d      = bcd_q;
    digit_en_d = digit_en_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          bin_d   = bus.i_value;
          work_d  = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d   = bin_shift;
        work_d  = work_shift;
        carry_d = final_ovf;
        cnt_d   = cnt_q + CW'(1);
        if (last_shift) begin
          bcd_d      = work_shift;
          digit_en_d = en_final;
          overflow_d = final_ovf;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear overrides everything, including a start seen in IDLE.
    if (bus.i_clear) begin
      state_d    = S_IDLE;
      bin_d      = '0;
      work_d     = '0;
      cnt_d      = '0;
      carry_d    = 1'b0;
      bcd_d      = '0;
      digit_en_d = DIGITS'(1);
      overflow_d = 1'b0;
    end
  end

  // Status flags are registered copies of the next state so they line up
  // exactly with the state they describe.
  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      bcd_q      <= '0;
      digit_en_q <= DIGITS'(1);
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      bcd_q      <= bcd_d;
      digit_en_q <= digit_en_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_bcd      = bcd_q;
  assign bus.o_digit_en = digit_en_q;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_converter
// Self-checking bench for bcd_digit_converter: a default-size instance
// (14 bits, 4 digits) driven from a vector table plus corner-case sequences,
// and two 8-bit instances (3 and 2 digits) swept over every operand.
// ---------------------------------------------------------------------------
module tb_bcd_digit_converter;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_digit_converter_if #(.DATA_WIDTH(14), .DIGITS(4)) bus14 ();
  bcd_digit_converter_if #(.DATA_WIDTH(8),  .DIGITS(3)) bus8 ();
  bcd_digit_converter_if #(.DATA_WIDTH(8),  .DIGITS(2)) bus2 ();

  bcd_digit_converter #(.DATA_WIDTH(14), .DIGITS(4)) u_dut14 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus14));
  bcd_digit_converter #(.DATA_WIDTH(8), .DIGITS(3)) u_dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus8));
  bcd_digit_converter #(.DATA_WIDTH(8), .DIGITS(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] value;
    logic [15:0] bcd;
    logic [3:0]  en;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion on the 14-bit instance, checking latency and results.
  task automatic conv14(input logic [13:0] v, input logic [15:0] exp_bcd,
                        input logic [3:0] exp_en, input logic exp_ovf);
    int edges;
    bus14.i_value = v;
    bus14.i_start = 1'b1;
    @(posedge clk); #1;
    bus14.i_start = 1'b0;
    bus14.i_value = 14'($urandom);   // must not disturb the captured operand
    chk("busy_after_start14", bus14.o_busy, 1);
    edges = 0;
    while (!bus14.o_done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency14", edges, 14);
    chk("bcd14", bus14.o_bcd, exp_bcd);
    chk("digit_en14", bus14.o_digit_en, exp_en);
    chk("overflow14", bus14.o_overflow, exp_ovf);
    $display("conv14 value=%0d bcd=%h en=%b ovf=%b latency=%0d",
             v, bus14.o_bcd, bus14.o_digit_en, bus14.o_overflow, edges);
    @(posedge clk); #1;
    chk("done_pulse_end14", bus14.o_done, 0);
    chk("idle_after_done14", bus14.o_busy, 0);
  endtask

  // One conversion on both 8-bit instances against an arithmetic model.
  task automatic conv8(input int v);
    int edges;
    logic [11:0] e_bcd3;
    logic [2:0]  e_en3;
    logic [7:0]  e_bcd2;
    logic [1:0]  e_en2;
    logic        e_ovf2;
    e_bcd3 = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    e_en3  = {v >= 100, v >= 10, 1'b1};
    e_bcd2 = {4'(v / 10 % 10), 4'(v % 10)};
    e_ovf2 = (v >= 100);
    e_en2  = {(v >= 100) || ((v % 100) >= 10), 1'b1};
    bus8.i_value = 8'(v);
    bus2.i_value = 8'(v);
    bus8.i_start = 1'b1;
    bus2.i_start = 1'b1;
    @(posedge clk); #1;
    bus8.i_start = 1'b0;
    bus2.i_start = 1'b0;
    edges = 0;
    while (!bus8.o_done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency8", edges, 8);
    chk("done_d2", bus2.o_done, 1);
    chk("bcd_d3", bus8.o_bcd, e_bcd3);
    chk("en_d3", bus8.o_digit_en, e_en3);
    chk("ovf_d3", bus8.o_overflow, 0);
    chk("bcd_d2", bus2.o_bcd, e_bcd2);
    chk("en_d2", bus2.o_digit_en, e_en2);
    chk("ovf_d2", bus2.o_overflow, e_ovf2);
    $display("conv8 value=%0d d3=%h/%b d2=%h/%b/%b",
             v, bus8.o_bcd, bus8.o_digit_en, bus2.o_bcd, bus2.o_digit_en, bus2.o_overflow);
    @(posedge clk); #1;
  endtask

  // Count o_done pulses of the 14-bit instance over a window.
  task automatic count_done14(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus14.o_done) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    vecs[0] = '{14'd1234,  16'h1234, 4'b1111, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 4'b0001, 1'b0};
    vecs[2] = '{14'd42,    16'h0042, 4'b0011, 1'b0};
    vecs[3] = '{14'd9999,  16'h9999, 4'b1111, 1'b0};
    vecs[4] = '{14'd16383, 16'h6383, 4'b1111, 1'b1};
    vecs[5] = '{14'd10000, 16'h0000, 4'b1111, 1'b1};
    vecs[6] = '{14'd7,     16'h0007, 4'b0001, 1'b0};
    vecs[7] = '{14'd305,   16'h0305, 4'b0111, 1'b0};
    vecs[8] = '{14'd1000,  16'h1000, 4'b1111, 1'b0};
    vecs[9] = '{14'd10099, 16'h0099, 4'b1111, 1'b1};

    rst_n = 1'b0;
    bus14.i_clear = 1'b0; bus14.i_start = 1'b0; bus14.i_value = '0;
    bus8.i_clear  = 1'b0; bus8.i_start  = 1'b0; bus8.i_value  = '0;
    bus2.i_clear  = 1'b0; bus2.i_start  = 1'b0; bus2.i_value  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus14.o_busy, 0);
    chk("rst_done", bus14.o_done, 0);
    chk("rst_bcd", bus14.o_bcd, 0);
    chk("rst_en", bus14.o_digit_en, 4'b0001);
    chk("rst_ovf", bus14.o_overflow, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven conversions, issued back-to-back at minimum spacing.
    for (int i = 0; i < 10; i++)
      conv14(vecs[i].value, vecs[i].bcd, vecs[i].en, vecs[i].ovf);

    // Start and operand changes while busy are ignored.
    bus14.i_value = 14'd1234;
    bus14.i_start = 1'b1;
    @(posedge clk); #1;
    bus14.i_value = 14'd5678;
    nd = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (bus14.o_done) nd++;
    end
    bus14.i_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus14.o_done) nd++;
    end
    chk("busy_start_single_done", nd, 1);
    chk("busy_start_result", bus14.o_bcd, 16'h1234);
    $display("seq start_while_busy done_pulses=%0d bcd=%h", nd, bus14.o_bcd);

    // Clear during SHIFT aborts with no done and zeroed results.
    bus14.i_value = 14'd9876;
    bus14.i_start = 1'b1;
    @(posedge clk); #1;
    bus14.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus14.i_clear = 1'b1;
    @(posedge clk); #1;
    bus14.i_clear = 1'b0;
    chk("clr_busy", bus14.o_busy, 0);
    chk("clr_done", bus14.o_done, 0);
    chk("clr_bcd", bus14.o_bcd, 0);
    chk("clr_en", bus14.o_digit_en, 4'b0001);
    chk("clr_ovf", bus14.o_overflow, 0);
    count_done14(20, nd);
    chk("clr_no_done", nd, 0);
    $display("seq clear_mid_shift done_pulses=%0d bcd=%h", nd, bus14.o_bcd);

    // Start together with clear in IDLE is not accepted.
    bus14.i_value = 14'd4321;
    bus14.i_start = 1'b1;
    bus14.i_clear = 1'b1;
    @(posedge clk); #1;
    bus14.i_start = 1'b0;
    bus14.i_clear = 1'b0;
    chk("start_clr_busy", bus14.o_busy, 0);
    count_done14(20, nd);
    chk("start_clr_no_done", nd, 0);
    $display("seq start_with_clear done_pulses=%0d", nd);

    // Asynchronous reset in the middle of SHIFT.
    conv14(14'd9999, 16'h9999, 4'b1111, 1'b0);
    bus14.i_value = 14'd1234;
    bus14.i_start = 1'b1;
    @(posedge clk); #1;
    bus14.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus14.o_busy, 0);
    chk("arst_done", bus14.o_done, 0);
    chk("arst_bcd", bus14.o_bcd, 0);
    chk("arst_en", bus14.o_digit_en, 4'b0001);
    chk("arst_ovf", bus14.o_overflow, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    count_done14(20, nd);
    chk("arst_no_done", nd, 0);
    chk("arst_idle", bus14.o_busy, 0);
    $display("seq async_reset_mid_shift done_pulses=%0d", nd);
    conv14(14'd4321, 16'h4321, 4'b1111, 1'b0);

    // Every 8-bit operand on the 3-digit and 2-digit instances.
    for (int v = 0; v < 256; v++) conv8(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_converter.md
BCD_DIGIT_CONVERTER -- requirements
Module: bcd_digit_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, binary input width (legal 4..32).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits (legal 1..10).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_clear  input  1  synchronous clear; zeroes results and aborts any conversion.
REQ-006 SHALL have port i_start  input  1  conversion request; sampled only in IDLE.
REQ-007 SHALL have port i_value  input  DATA_WIDTH  unsigned binary operand; captured on the accepting edge.
REQ-008 SHALL have port o_busy  output  1  high in SHIFT and DONE.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse; results valid and updated.
REQ-010 SHALL have port o_bcd  output  4*DIGITS  packed digits; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
REQ-011 SHALL have port o_digit_en  output  DIGITS  leading-zero blank mask; bit k high if digit k is significant.
REQ-012 SHALL have port o_overflow  output  1  i_value >= 10^DIGITS for the last conversion.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE: if i_start=1 and i_clear=0 on an edge, SHALL capture i_value into a DATA_WIDTH shift register, zero a 4*DIGITS working BCD register, zero the bit counter and sticky carry, and enter SHIFT.
REQ-015 SHIFT: each cycle, SHALL add 3 to every working nibble >= 5, then shift {BCD, binary} left by one, MSB of the binary register entering BCD bit 0 (double dabble).
REQ-016 SHALL set the sticky carry whenever a 1 is shifted out of the top BCD nibble.
REQ-017 SHIFT SHALL last exactly DATA_WIDTH cycles; on the edge completing the last shift, SHALL load o_bcd, o_digit_en and o_overflow and enter DONE.
REQ-018 DONE SHALL last one cycle with o_done=1, then return to IDLE; o_done is registered (high exactly when state is DONE).
REQ-019 Latency: start accepted on edge E; o_done high for the cycle following edge E+DATA_WIDTH; minimum start-to-start spacing DATA_WIDTH+2 cycles.
REQ-020 o_bcd SHALL equal i_value mod 10^DIGITS, each digit in 0..9.
REQ-021 o_overflow SHALL equal the sticky carry (1 iff i_value >= 10^DIGITS).
REQ-022 o_digit_en[0] SHALL be 1 always; bit k>0 SHALL be 1 iff any digit j>=k is nonzero; when o_overflow=1 all bits SHALL be 1.
REQ-023 i_start while busy (SHIFT or DONE) SHALL be ignored, with no queuing; i_value changes after capture SHALL not affect the result.
REQ-024 o_bcd, o_digit_en and o_overflow SHALL hold their values between conversions until the next DONE load or a clear/reset.
REQ-025 i_clear=1 on any edge SHALL force IDLE, o_bcd=0, o_digit_en=1 (bit 0 only), o_overflow=0, o_done=0; clear SHALL take priority over simultaneous i_start.
REQ-026 i_clear during SHIFT SHALL abort the conversion with no o_done pulse.

Reset
REQ-027 i_reset_n=0 SHALL immediately, without a clock, force IDLE, o_busy=0, o_done=0, o_bcd=0, o_digit_en=1 (bit 0 only), o_overflow=0, and clear counter, shift and working registers.
REQ-028 Reset asserted mid-conversion SHALL discard the conversion; no o_done pulse follows reset release.
REQ-029 After reset release, the first edge with i_start=1 SHALL be accepted.

Verification
REQ-030 Defaults, i_value=1234, 1-cycle start -> o_busy high next cycle; o_done pulses once, exactly 14 edges after the start edge; o_bcd=0x1234, o_digit_en=4'b1111, o_overflow=0.
REQ-031 i_value=0 -> o_bcd=0x0000, o_digit_en=4'b0001; i_value=42 -> 0x0042, 4'b0011; i_value=9999 -> 0x9999, o_overflow=0.
REQ-032 i_value=16383 -> o_bcd=0x6383, o_overflow=1, o_digit_en=4'b1111.
REQ-033 Start 1234, then i_start pulses and i_value=5678 during SHIFT -> single o_done, result 0x1234; i_clear at shift cycle 5 -> no o_done, o_bcd=0, IDLE; simultaneous start+clear in IDLE -> not accepted.
REQ-034 i_reset_n low asynchronously mid-SHIFT -> outputs are at reset values before the next edge; no o_done after release; next start converts normally.
REQ-035 DATA_WIDTH=8, DIGITS=3: exhaustive 0..255 vs. a reference model, e.g. 255 -> 0x255, o_done 8 edges after start; DIGITS=2: 100 -> 0x00, overflow=1.
